// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between an initiator and data_mem_responder.
// Requests use valid/ready on the req_* group; responses use valid/ready on the rsp_* group.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose: single-outstanding byte/half/word data memory with fixed response latency.
// Latency: rsp_valid rises LATENCY edges after the accept edge; backpressure: rsp held until rsp_ready, req_ready only in IDLE.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic clk,
    input  logic rst_n,
    data_mem_responder_if.slave bus
);
    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    req_t        req_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          rsp_done;
    logic          err;
    logic [AW-1:0] idx;
    logic [4:0]    shamt;
    logic [31:0]   cur_word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [31:0]   lane_mask;
    logic [31:0]   merged;

    assign accept     = (state_q == ST_IDLE) && bus.req_valid;
    assign enter_resp = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign rsp_done   = (state_q == ST_RESP) && bus.rsp_ready;

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Error decode works on the captured request so later req_* changes cannot leak in.
    always_comb begin
        err = 1'b0;
        if (req_q.size == 2'b11)                                   err = 1'b1;
        if (req_q.size == 2'b01 && req_q.addr[0])                  err = 1'b1;
        if (req_q.size == 2'b10 && req_q.addr[1:0] != 2'b00)       err = 1'b1;
        if ({2'b00, req_q.addr[31:2]} >= 32'(DEPTH_WORDS))         err = 1'b1;
    end

    assign idx      = req_q.addr[AW+1:2];
    assign shamt    = {req_q.addr[1:0], 3'b000};
    assign cur_word = mem[idx];
    assign shifted  = cur_word >> shamt;

    always_comb begin
        load_data = cur_word;
        lane_mask = 32'hFFFF_FFFF;
        unique case (req_q.size)
            2'b00: begin
                load_data = {{24{req_q.sgn & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                load_data = {{16{req_q.sgn & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: begin
                load_data = cur_word;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign merged = (cur_word & ~lane_mask) | ((req_q.wdata << shamt) & lane_mask);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)         state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 4'd0)  state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready)  state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                req_q <= '{we: bus.req_we, addr: bus.req_addr, size: bus.req_size,
                           sgn: bus.req_signed, wdata: bus.req_wdata};
                cnt_q <= CNT_LOAD;
            end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err;
                rsp_rdata_q <= (err || req_q.we) ? 32'd0 : load_data;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= 32'd0;
            end
        end
    end

    // Storage is deliberately not reset; a reset before commit drops the store.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && req_q.we && !err)
            mem[idx] <= merged;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-addressed reference memory.
// Directed sequences cover the known-answer cases, backpressure hold and reset abort.
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] ref_bytes [DEPTH*4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1 && (a % 2) != 0) return 1'b1;
        if (s == 2'd2 && (a % 4) != 0) return 1'b1;
        return (a / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic sgn);
        logic [31:0] v = 0;
        int n = 1 << s;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
        if (sgn && s == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && s == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int n = 1 << s;
        for (int i = 0; i < n; i++) ref_bytes[a + i] = 8'(d >> (8 * i));
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata, input int hold,
                           output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        int          guard;
        exp_err = model_err(addr, size);
        exp_rd  = 32'd0;
        if (!exp_err && !we) exp_rd = model_load(addr, size, sgn);

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_wdata  = wdata;
        bus.rsp_ready  = 1'b0;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        // Junk request held valid while busy must be ignored.
        @(negedge clk);
        bus.req_we     = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_wdata  = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat < LAT) check("early_ready", 32'(bus.req_ready), 32'd0);
        end while (!bus.rsp_valid && lat < 20);
        check("latency", 32'(lat), 32'(LAT));
        got_rdata = bus.rsp_rdata;
        got_err   = bus.rsp_err;
        check("rdata", got_rdata, exp_rd);
        check("err", 32'(got_err), 32'(exp_err));
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", bus.rsp_rdata, exp_rd);
            check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
            check("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        check("hs_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_hs_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (we && !exp_err) model_store(addr, size, wdata);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        logic [1:0]  s;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);

        for (int i = 0; i < DEPTH; i++) run_txn(1'b1, 32'(i * 4), 2'd2, 1'b0, $urandom, 0, rd, er);

        run_txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, rd, er);
        run_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, rd, er);
        check("kat_word", rd, 32'hDEADBEEF);
        run_txn(1'b1, 32'h11, 2'd0, 1'b0, 32'h55, 0, rd, er);
        run_txn(1'b0, 32'h13, 2'd0, 1'b1, 32'd0, 0, rd, er);
        check("kat_lb", rd, 32'hFFFFFFDE);
        run_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, rd, er);
        check("kat_merge", rd, 32'hDEAD55EF);
        run_txn(1'b0, 32'h12, 2'd1, 1'b0, 32'd0, 0, rd, er);
        check("kat_lhu", rd, 32'h0000DEAD);

        run_txn(1'b0, 32'h06, 2'd2, 1'b0, 32'd0, 0, rd, er);
        check("kat_err_w", {31'd0, er}, 32'd1);
        run_txn(1'b0, 32'h03, 2'd1, 1'b0, 32'd0, 0, rd, er);
        check("kat_err_h", {31'd0, er}, 32'd1);
        run_txn(1'b1, 32'h10, 2'd3, 1'b0, 32'h0BAD0BAD, 0, rd, er);
        check("kat_err_sz", {31'd0, er}, 32'd1);
        run_txn(1'b1, 32'h400, 2'd2, 1'b0, 32'h0BAD0BAD, 0, rd, er);
        check("kat_err_rng", {31'd0, er}, 32'd1);
        run_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 5, rd, er);
        check("kat_after_err", rd, 32'hDEAD55EF);

        // Reset one cycle after accepting a store must drop it.
        run_txn(1'b1, 32'h20, 2'd2, 1'b0, 32'hA5A5A5A5, 0, rd, er);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_size  = 2'd2;
        bus.req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rdata", bus.rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("abort_quiet", 32'(bus.rsp_valid), 32'd0);
        end
        run_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 0, rd, er);
        check("abort_nowrite", rd, 32'hA5A5A5A5);

        for (int n = 0; n < 300; n++) begin
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 9) < 7) begin
                if (s == 2'd1) a = a & ~32'd1;
                if (s == 2'd2) a = a & ~32'd3;
            end
            run_txn(1'($urandom), a, s, 1'($urandom), $urandom, $urandom_range(0, 2), rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
